// File: rtl/vcpu_pkg.sv
// Shared definitions for the vector CPU datapath.
// Holds the vector geometry (lane count, lane width, register address
// width), the packed vector type used on the register-file ports
// (WD3/RD1/RD2), and the state encoding of the load packer.
package vcpu_pkg;

  localparam int LANES  = 6;
  localparam int LANE_W = 8;
  localparam int REG_AW = 4;

  // Lane 0 occupies the least-significant LANE_W bits.
  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2
  } pack_state_t;

endpackage

// File: rtl/vreg_load_packer.sv
// vreg_load_packer: gathers a byte-serial memory stream into one vector
// and writes it to register-file port 3 for a single cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, dest         load command strobe and destination register
//   flush               abort an in-progress collection
//   mem_valid, mem_data byte stream from data memory
//   mem_ready           a byte is accepted this cycle when valid is high
//   busy                a load is in progress (not IDLE)
//   done                one-cycle completion pulse, same cycle as WE3
//   WE3, A3, WD3        register-file write port
module vreg_load_packer #(
  parameter int LANES  = vcpu_pkg::LANES,
  parameter int LANE_W = vcpu_pkg::LANE_W,
  parameter int REG_AW = vcpu_pkg::REG_AW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [REG_AW-1:0]             dest,
  input  logic                          flush,
  input  logic                          mem_valid,
  input  logic [LANE_W-1:0]             mem_data,
  output logic                          mem_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          WE3,
  output logic [REG_AW-1:0]             A3,
  output logic [LANES-1:0][LANE_W-1:0]  WD3
);

  import vcpu_pkg::*;

  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

  pack_state_t                 state;
  pack_state_t                 state_next;
  logic [CNT_W-1:0]            cnt;
  logic [REG_AW-1:0]           dest_q;
  logic [LANES-1:0][LANE_W-1:0] lane_buf;

  logic start_acc;
  logic beat;
  logic last_beat;

  // A start is only honoured when no collection is running; in WRITE this
  // lets the next load begin with zero idle cycles.
  assign start_acc = start & ((state == IDLE) | (state == WRITE));
  assign beat      = mem_valid & mem_ready;
  assign last_beat = beat & (cnt == LAST_LANE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: begin
        // flush outranks a beat arriving in the same cycle
        if (flush)          state_next = IDLE;
        else if (last_beat) state_next = WRITE;
      end
      WRITE:   state_next = start ? COLLECT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The clear on start lands on the same edge the register file captures
  // the previous vector, so back-to-back loads never corrupt the old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_buf <= '0;
    end else if (start_acc) begin
      lane_buf <= '0;
    end else if (beat) begin
      lane_buf[cnt] <= mem_data;
    end
  end

  // Holds at the last lane instead of wrapping; the FSM leaves COLLECT on
  // that beat so the counter is never consulted again before a restart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start_acc) begin
      cnt <= '0;
    end else if (beat && (cnt != LAST_LANE)) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_q <= '0;
    end else if (start_acc) begin
      dest_q <= dest;
    end
  end

  always_comb begin
    mem_ready = (state == COLLECT) & ~flush;
    busy      = (state != IDLE);
    WE3       = (state == WRITE);
    done      = (state == WRITE);
    A3        = dest_q;
    WD3       = lane_buf;
  end

endmodule

// File: doc/vreg_load_packer.md
# vreg_load_packer

Write-side companion of the vector register file. It accepts a byte-serial stream from data memory for a vector load, packs six bytes into one 6×8-bit vector, then drives the register-file write port (`WE3`/`A3`/`WD3`) for exactly one cycle. It sits between the load/store unit's memory interface and the register file's port 3.

## Interface
- `LANES`, default 6: vector lanes per register.
- `LANE_W`, default 8: bits per lane.
- `REG_AW`, default 4: register address width (16 registers).

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: load command strobe.
- `dest` in REG_AW: destination register, sampled with an accepted `start`.
- `flush` in 1: abort the in-progress collection.
- `mem_valid` in 1: memory byte valid.
- `mem_data` in LANE_W: memory byte.
- `mem_ready` out 1: packer accepts a byte this cycle.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse, coincident with `WE3`.
- `WE3` out 1: register-file write enable.
- `A3` out REG_AW: register-file write address.
- `WD3` out LANES×LANE_W: packed vector, lane 0 = least-significant byte.

## Operation
- **State machine** (states: IDLE, COLLECT, WRITE):
  - IDLE →COLLECT on `start`.
  - COLLECT →WRITE when the beat for lane `LANES-1` is accepted.
  - COLLECT →IDLE on `flush`.
  - WRITE →COLLECT if `start` is high, else →IDLE.
- **Start acceptance:** `start` is accepted only in IDLE or WRITE and is ignored in COLLECT. On acceptance:
  - `dest` is latched into `dest_q`.
  - The lane buffer is cleared to 0.
  - The lane counter is cleared to 0.
- **Beat accept:** a beat is accepted when `mem_valid & mem_ready`.
  - `mem_data` is written to `buf[cnt]` and `cnt` increments.
  - `mem_ready` = (state == COLLECT) & ~`flush`. It is combinational from the state register and `flush`.
- **Flush:**
  - In COLLECT, `flush` wins over a simultaneous beat. The beat is not accepted and no write occurs.
  - In IDLE and WRITE, `flush` is ignored. A write that has reached WRITE always completes.
- **Output drive:**
  - `WE3` = `done` = (state == WRITE).
  - `A3` = `dest_q`.
  - `WD3` = `buf`, driven continuously. Partial contents are visible during COLLECT, but the value is only meaningful while `WE3` is high.
  - `busy` = (state != IDLE).
- **Counter:** `cnt` is ceil(log2(LANES)) bits and never wraps past `LANES-1`. The transition to WRITE is taken on the final beat.
- **Reset values:**
  - State: IDLE.
  - `cnt`, `dest_q`, `buf`: 0.
  - Outputs: `WE3`=0, `done`=0, `busy`=0, `mem_ready`=0, `A3`=0, `WD3`=0.

## Timing
- **Latency:** `start` is sampled at edge k. With `mem_valid` held high, beats are accepted at edges k+1…k+6. `WE3` is high for the single cycle between edges k+6 and k+7. The register file captures the vector at edge k+7.
- **Minimum load:** LANES+1 cycles from the start edge to the write edge. Each cycle of `mem_valid`=0 in COLLECT adds exactly one cycle.
- **Back-to-back:** a `start` in the WRITE cycle gives zero idle cycles between loads. The buffer clear happens at the same edge the register file captures the old `WD3`, so the old data is written intact.
- **Reset:** asynchronous `rst_n` assertion forces all reset values immediately, including mid-COLLECT and mid-WRITE. Release is synchronous to the next `clk` edge.

## Structure
- Shared package `vcpu_pkg` holds:
  - `LANES`, `LANE_W`, `REG_AW`.
  - `typedef logic [LANES-1:0][LANE_W-1:0] vec_t`, which is also used for the register-file `WD3`/`RD1`/`RD2`.
  - Enum `pack_state_t` {IDLE, COLLECT, WRITE}.
- Single module, no sub-modules. Buffer, counter and FSM are each one `always_ff` with async active-low reset; outputs use `always_comb`.

## Test plan
- **Reset:** assert `rst_n`=0 with random inputs → all outputs 0 and `mem_ready`=0. Deassert → still idle.
- **Basic load:** `start`, `dest`=1; bytes CD, AB, 34, 12, 00, 00 with continuous `mem_valid` → `WE3` high for exactly one cycle, 7 cycles after the start edge, with `A3`=1 and `WD3`=0x00001234ABCD. Regfile read with `A1`=1 returns that value.
- **Stalls:** `mem_valid` low for 3 cycles after lane 2 → the counter holds, `WE3` arrives 3 cycles later, and the data is identical.
- **Flush:** assert `flush` together with the 4th beat → no `WE3`, and `busy`=0 next cycle. A following load to `dest`=2 with bytes 11..66 yields `WD3`=0x665544332211, with no stale lanes.
- **Simultaneous start:** `start` with `dest`=3 during the WRITE cycle of a load to register 1 → register 1 is written, then COLLECT begins immediately with `A3`=3. A `start` with `dest`=5 during that COLLECT is ignored and `A3` stays 3.
- **Async reset mid-load:** `rst_n` pulsed low after 2 beats → outputs clear within the same cycle, no `WE3` occurs, and the next load behaves as in the basic-load scenario.
